// File: rtl/control_sequencer.sv
// Microcoded T-state sequencer for the 4-bit accumulator CPU.
// Decodes step/opcode/flags into datapath strobes and tracks the halt state.
module control_sequencer #(
  parameter int OPCODE_WIDTH = 4,
  parameter int STEP_WIDTH   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    step_en,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    carry,
  input  logic                    zero,
  output logic                    pc_enable,
  output logic                    pc_jump,
  output logic                    pc_out,
  output logic                    mar_in,
  output logic                    ram_in,
  output logic                    ram_out,
  output logic                    ir_in,
  output logic                    ir_out,
  output logic                    a_in,
  output logic                    a_out,
  output logic                    b_in,
  output logic                    alu_out,
  output logic                    alu_sub,
  output logic                    flags_in,
  output logic                    out_in,
  output logic                    halt,
  output logic [STEP_WIDTH-1:0]   step
);

  localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'h1);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'h2);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'h3);
  localparam logic [OPCODE_WIDTH-1:0] OP_STA = OPCODE_WIDTH'(4'h4);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDI = OPCODE_WIDTH'(4'h5);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'h6);
  localparam logic [OPCODE_WIDTH-1:0] OP_JC  = OPCODE_WIDTH'(4'h7);
  localparam logic [OPCODE_WIDTH-1:0] OP_JZ  = OPCODE_WIDTH'(4'h8);
  localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'hE);
  localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'hF);

  localparam logic [STEP_WIDTH-1:0] T0 = STEP_WIDTH'(0);
  localparam logic [STEP_WIDTH-1:0] T1 = STEP_WIDTH'(1);
  localparam logic [STEP_WIDTH-1:0] T2 = STEP_WIDTH'(2);
  localparam logic [STEP_WIDTH-1:0] T3 = STEP_WIDTH'(3);
  localparam logic [STEP_WIDTH-1:0] T4 = STEP_WIDTH'(4);

  logic [STEP_WIDTH-1:0] step_q;
  logic [STEP_WIDTH-1:0] step_d;
  logic [STEP_WIDTH-1:0] last;
  logic                  halted_q;
  logic                  halted_d;
  logic                  act;

  assign act  = step_en & rst_n & ~halted_q;
  assign halt = halted_q;
  assign step = step_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    last = T2;
    case (opcode)
      OP_LDA, OP_STA: last = T3;
      OP_ADD, OP_SUB: last = T4;
      default:        last = T2;
    endcase
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (act) begin
      if (step_q == last) begin
        step_d   = T0;
        halted_d = (opcode == OP_HLT);
      end else begin
        step_d = step_q + STEP_WIDTH'(1);
      end
    end
  end

  // Fetch is opcode-independent; execute decodes per opcode and step.
  always_comb begin
    pc_enable = 1'b0;
    pc_jump   = 1'b0;
    pc_out    = 1'b0;
    mar_in    = 1'b0;
    ram_in    = 1'b0;
    ram_out   = 1'b0;
    ir_in     = 1'b0;
    ir_out    = 1'b0;
    a_in      = 1'b0;
    a_out     = 1'b0;
    b_in      = 1'b0;
    alu_out   = 1'b0;
    alu_sub   = 1'b0;
    flags_in  = 1'b0;
    out_in    = 1'b0;
    if (act) begin
      unique case (1'b1)
        (step_q == T0): begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        (step_q == T1): begin
          ram_out   = 1'b1;
          ir_in     = 1'b1;
          pc_enable = 1'b1;
        end
        (step_q == T2): begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OP_LDI: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_jump = 1'b1;
            end
            OP_JC: begin
              ir_out  = carry;
              pc_jump = carry;
            end
            OP_JZ: begin
              ir_out  = zero;
              pc_jump = zero;
            end
            OP_OUT: begin
              a_out  = 1'b1;
              out_in = 1'b1;
            end
            default: ;
          endcase
        end
        (step_q == T3): begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OP_STA: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        (step_q == T4): begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out  = 1'b1;
            a_in     = 1'b1;
            flags_in = 1'b1;
            alu_sub  = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer against a microcode-table model.
// Randomized opcodes, flags, stalls and resets are scored every cycle.
module tb_control_sequencer;

  logic       clk;
  logic       rst_n;
  logic       step_en;
  logic [3:0] opcode;
  logic       carry;
  logic       zero;
  logic       pc_enable, pc_jump, pc_out, mar_in, ram_in, ram_out;
  logic       ir_in, ir_out, a_in, a_out, b_in, alu_out, alu_sub;
  logic       flags_in, out_in, halt;
  logic [2:0] step;

  int checks = 0;
  int failures = 0;

  localparam logic [14:0] S_PCE  = 15'h4000;
  localparam logic [14:0] S_PCJ  = 15'h2000;
  localparam logic [14:0] S_PCO  = 15'h1000;
  localparam logic [14:0] S_MAR  = 15'h0800;
  localparam logic [14:0] S_RAMI = 15'h0400;
  localparam logic [14:0] S_RAMO = 15'h0200;
  localparam logic [14:0] S_IRI  = 15'h0100;
  localparam logic [14:0] S_IRO  = 15'h0080;
  localparam logic [14:0] S_AI   = 15'h0040;
  localparam logic [14:0] S_AO   = 15'h0020;
  localparam logic [14:0] S_BI   = 15'h0010;
  localparam logic [14:0] S_ALUO = 15'h0008;
  localparam logic [14:0] S_SUB  = 15'h0004;
  localparam logic [14:0] S_FLG  = 15'h0002;
  localparam logic [14:0] S_OUTI = 15'h0001;

  logic [14:0] strobes;
  assign strobes = {pc_enable, pc_jump, pc_out, mar_in, ram_in,
                    ram_out, ir_in, ir_out, a_in, a_out, b_in,
                    alu_out, alu_sub, flags_in, out_in};

  control_sequencer dut (
    .clk(clk), .rst_n(rst_n), .step_en(step_en), .opcode(opcode),
    .carry(carry), .zero(zero), .pc_enable(pc_enable),
    .pc_jump(pc_jump), .pc_out(pc_out), .mar_in(mar_in),
    .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in),
    .ir_out(ir_out), .a_in(a_in), .a_out(a_out), .b_in(b_in),
    .alu_out(alu_out), .alu_sub(alu_sub), .flags_in(flags_in),
    .out_in(out_in), .halt(halt), .step(step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: microcode ROM plus instruction lengths.
  logic [14:0] ucode [16][5];
  int          ulen  [16];
  int          mstep;
  bit          mhalt;

  task automatic build_ucode();
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 5; s++) ucode[op][s] = '0;
      ucode[op][0] = S_PCO | S_MAR;
      ucode[op][1] = S_RAMO | S_IRI | S_PCE;
      ulen[op] = 3;
    end
    ucode[1][2] = S_IRO | S_MAR;  ucode[1][3] = S_RAMO | S_AI;  ulen[1] = 4;
    for (int op = 2; op <= 3; op++) begin
      ucode[op][2] = S_IRO | S_MAR;
      ucode[op][3] = S_RAMO | S_BI;
      ucode[op][4] = S_ALUO | S_AI | S_FLG | (op == 3 ? S_SUB : 15'h0);
      ulen[op] = 5;
    end
    ucode[4][2] = S_IRO | S_MAR;  ucode[4][3] = S_AO | S_RAMI;  ulen[4] = 4;
    ucode[5][2] = S_IRO | S_AI;
    ucode[6][2] = S_IRO | S_PCJ;
    ucode[14][2] = S_AO | S_OUTI;
  endtask

  function automatic logic [14:0] exp_strobes();
    bit f;
    if (!rst_n || !step_en || mhalt) return '0;
    if (mstep == 2 && (opcode == 4'h7 || opcode == 4'h8)) begin
      f = (opcode == 4'h7) ? carry : zero;
      return f ? (S_IRO | S_PCJ) : 15'h0;
    end
    return ucode[opcode][mstep];
  endfunction

  task automatic clk_edge();
    @(posedge clk);
    if (!rst_n) begin
      mstep = 0;
      mhalt = 0;
    end else if (step_en && !mhalt) begin
      if (mstep == ulen[opcode] - 1) begin
        mstep = 0;
        if (opcode == 4'hF) mhalt = 1;
      end else begin
        mstep++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clk_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; step_en = 1'b1; opcode = 4'h2; carry = 1; zero = 1;
    clk_edge();
    @(negedge clk);
    checks++;
    if ({strobes, step, halt} !== 19'h0) begin
      $display("FAIL reset_state strobes=%h step=%0d halt=%b want all 0",
               strobes, step, halt);
      failures++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fetch();
    logic [14:0] want [2];
    want[0] = S_PCO | S_MAR;
    want[1] = S_RAMO | S_IRI | S_PCE;
    do_reset();
    opcode = 4'($urandom_range(0, 14));
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (strobes !== want[c] || step !== 3'(c)) begin
        $display("FAIL fetch_T%0d strobes=%h step=%0d want %h step %0d",
                 c, strobes, step, want[c], c);
        failures++;
      end
      clk_edge();
    end
    @(negedge clk);
    checks++;
    if (step !== 3'd2) begin
      $display("FAIL fetch_to_T2 step=%0d want 2", step);
      failures++;
    end
  endtask

  task automatic test_alu_ops();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      opcode = (k == 0) ? 4'h2 : 4'h3;
      for (int c = 0; c < 5; c++) begin
        carry = 1'($urandom); zero = 1'($urandom);
        @(negedge clk);
        checks++;
        if (strobes !== exp_strobes() || step !== 3'(mstep)
            || alu_sub !== (k == 1 && c == 4)) begin
          $display("FAIL alu_op%0h_T%0d strobes=%h step=%0d want %h step %0d",
                   opcode, c, strobes, step, exp_strobes(), mstep);
          failures++;
        end
        clk_edge();
      end
      @(negedge clk);
      checks++;
      if (step !== 3'd0) begin
        $display("FAIL alu_op%0h_wrap step=%0d want 0", opcode, step);
        failures++;
      end
    end
  endtask

  task automatic test_cond_jumps();
    for (int k = 0; k < 4; k++) begin
      do_reset();
      opcode = (k < 2) ? 4'h7 : 4'h8;
      clk_edge(); clk_edge();
      carry = (k == 1); zero = (k == 3);
      @(negedge clk);
      checks++;
      if (strobes !== exp_strobes() || step !== 3'd2) begin
        $display("FAIL cjump_op%0h_flag%0d strobes=%h want %h",
                 opcode, k % 2, strobes, exp_strobes());
        failures++;
      end
      // Flag flip within T2 must be visible combinationally.
      carry = ~carry; zero = ~zero;
      #1;
      checks++;
      if (strobes !== exp_strobes() || pc_enable !== 1'b0) begin
        $display("FAIL cjump_flip_op%0h strobes=%h want %h",
                 opcode, strobes, exp_strobes());
        failures++;
      end
      clk_edge();
      @(negedge clk);
      checks++;
      if (step !== 3'd0) begin
        $display("FAIL cjump_wrap step=%0d want 0", step);
        failures++;
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    opcode = 4'h1;
    clk_edge(); clk_edge(); clk_edge();
    step_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (step !== 3'd3 || strobes !== 15'h0) begin
        $display("FAIL stall_%0d step=%0d strobes=%h want step 3 strobes 0",
                 c, step, strobes);
        failures++;
      end
      clk_edge();
    end
    step_en = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes !== (S_RAMO | S_AI)) begin
      $display("FAIL stall_release strobes=%h want %h", strobes, S_RAMO | S_AI);
      failures++;
    end
    clk_edge();
    @(negedge clk);
    checks++;
    if (step !== 3'd0) begin
      $display("FAIL stall_wrap step=%0d want 0", step);
      failures++;
    end
  endtask

  task automatic test_halt();
    do_reset();
    opcode = 4'hF;
    clk_edge(); clk_edge(); clk_edge();
    for (int c = 0; c < 10; c++) begin
      step_en = 1'b1;
      opcode = 4'($urandom);
      @(negedge clk);
      checks++;
      if (halt !== 1'b1 || step !== 3'd0 || strobes !== 15'h0) begin
        $display("FAIL halted_%0d halt=%b step=%0d strobes=%h want 1 0 0",
                 c, halt, step, strobes);
        failures++;
      end
      clk_edge();
    end
    do_reset();
    opcode = 4'h0;
    @(negedge clk);
    checks++;
    if (halt !== 1'b0 || strobes !== (S_PCO | S_MAR)) begin
      $display("FAIL halt_clear halt=%b strobes=%h want 0 %h",
               halt, strobes, S_PCO | S_MAR);
      failures++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 4'h4;
    clk_edge(); clk_edge(); clk_edge();
    rst_n = 1'b0;
    #1;
    checks++;
    if (strobes !== 15'h0) begin
      $display("FAIL reset_mid_gate strobes=%h want 0", strobes);
      failures++;
    end
    clk_edge();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (step !== 3'(c) || ram_in !== 1'b0 || strobes !== exp_strobes()) begin
        $display("FAIL reset_mid_%0d step=%0d strobes=%h want %0d %h",
                 c, step, strobes, c, exp_strobes());
        failures++;
      end
      clk_edge();
    end
  endtask

  task automatic test_random();
    logic [4:0] bus;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if (mstep == 0) opcode = 4'($urandom_range(0, 14));
      step_en = ($urandom_range(0, 9) != 0);
      rst_n   = ($urandom_range(0, 39) != 0);
      carry = 1'($urandom); zero = 1'($urandom);
      @(negedge clk);
      bus = {pc_out, ram_out, ir_out, a_out, alu_out};
      checks++;
      if (strobes !== exp_strobes() || step !== 3'(mstep) || halt !== mhalt
          || (pc_enable && pc_jump) || !$onehot0(bus)) begin
        $display("FAIL random_%0d op=%0h strobes=%h step=%0d halt=%b want %h %0d %b",
                 c, opcode, strobes, step, halt, exp_strobes(), mstep, mhalt);
        failures++;
      end
      clk_edge();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; step_en = 1'b0; opcode = '0; carry = 0; zero = 0;
    mstep = 0; mhalt = 0;
    build_ucode();
    test_reset();
    test_fetch();
    test_alu_ops();
    test_cond_jumps();
    test_stall();
    test_halt();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Microcoded control unit for the 4-bit-address accumulator CPU. It steps through fetch and execute micro-steps (T-states) and drives the control strobes of the datapath: the program counter's enable/jump/out_enable, MAR, RAM, IR, A, B, ALU, output register and flags. It sits directly upstream of the program counter and of every other bus agent, and consumes the opcode held in the instruction register plus the carry and zero flags.

Parameters:
OPCODE_WIDTH, 4, opcode field width; the encodings below require 4.
STEP_WIDTH, 3, T-state counter width; T0..T4 are used.

Ports:
clk  input  1  system clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
step_en  input  1  advance enable for single-step or run gating; when 0, state holds and all strobes are 0.
opcode  input  OPCODE_WIDTH  upper nibble of the IR; valid from T2.
carry  input  1  registered carry flag.
zero  input  1  registered zero flag.
pc_enable  output  1  PC increment.
pc_jump  output  1  PC load from bus.
pc_out  output  1  PC drives bus.
mar_in  output  1  MAR loads from bus.
ram_in  output  1  RAM write from bus.
ram_out  output  1  RAM drives bus.
ir_in  output  1  IR loads from bus.
ir_out  output  1  IR operand nibble drives bus.
a_in  output  1  A register load.
a_out  output  1  A register drives bus.
b_in  output  1  B register load.
alu_out  output  1  ALU drives bus.
alu_sub  output  1  ALU subtract select.
flags_in  output  1  flags register load.
out_in  output  1  output register load.
halt  output  1  CPU halted.
step  output  STEP_WIDTH  current T-state, for debug display.

Behaviour:
- State: step counter (0..4) and halted bit. Reset (rst_n=0 at posedge): step=0, halted=0.
- While rst_n=0, every strobe output is 0 (combinational gating). halt=0 after reset. step reads 0 after reset.
- Strobes are a combinational decode of (step, opcode, carry, zero), ANDed with step_en, rst_n and !halted.
- Advance on posedge when step_en=1 and !halted: if the current step is the opcode's last step, step<=0; otherwise step<=step+1. When step_en=0, step holds.
- Fetch, for all opcodes:
  - T0: pc_out, mar_in.
  - T1: ram_out, ir_in, pc_enable.
- Execute:
  - NOP 0x0: T2 no strobes, last.
  - LDA 0x1: T2 ir_out,mar_in; T3 ram_out,a_in, last.
  - ADD 0x2: T2 ir_out,mar_in; T3 ram_out,b_in; T4 alu_out,a_in,flags_in, last.
  - SUB 0x3: as ADD, with alu_sub also asserted in T4.
  - STA 0x4: T2 ir_out,mar_in; T3 a_out,ram_in, last.
  - LDI 0x5: T2 ir_out,a_in, last.
  - JMP 0x6: T2 ir_out,pc_jump, last.
  - JC 0x7: T2 ir_out,pc_jump only if carry=1, otherwise no strobes; last either way.
  - JZ 0x8: as JC, using zero.
  - OUT 0xE: T2 a_out,out_in, last.
  - HLT 0xF: T2 no strobes; on the advancing edge halted<=1 and step<=0.
  - Undefined 0x9..0xD: treated as NOP.
- Halted: halt=1, all strobes 0, step frozen at 0. Only reset clears it; step_en is ignored.
- Invariants:
  - pc_enable and pc_jump are never both 1.
  - At most one bus driver is active at a time: pc_out, ram_out, ir_out, a_out, alu_out.
- Flags are sampled combinationally in T2; a flag change mid-T2 changes the strobes within the same cycle.
- Reset mid-instruction abandons it; the next cycle after reset is T0 fetch.

Test Plan:
- Reset then 2 cycles, step_en=1: T0 gives pc_out=mar_in=1 and nothing else; T1 gives ram_out=ir_in=pc_enable=1; step goes 0→1→2.
- opcode=0x2 ADD over a full instruction: 5 cycles. T4 shows alu_out,a_in,flags_in=1 and alu_sub=0; step returns to 0 on the following cycle. Repeat with 0x3: alu_sub=1 in T4 only.
- opcode=0x7 JC with carry=0: T2 all strobes 0, next step=0. With carry=1: T2 ir_out=pc_jump=1 and pc_enable=0.
- step_en=0 held 3 cycles during T3 of LDA: step stays 3 and all strobes are 0. On release, ram_out,a_in=1 for one cycle, then step=0.
- opcode=0xF: after T2, halt=1, step=0, strobes 0 for 10 cycles with step_en=1. rst_n=0 for one edge gives halt=0, and T0 strobes resume.
- rst_n=0 asserted during T3 of STA: strobes are 0 immediately. After release, step=0 and no ram_in pulse occurs.
